// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner: scans a 4x4 active-low key matrix one row at a time,
// debounces a single key, reports its hex code with a one-cycle strobe and
// keeps a 3-bit display-select register loaded from keys 0-7.
module keypad_scanner #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [2:0] select
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEB,
    S_HELD
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       col_meta_q, col_meta_d;
  logic [3:0]       col_s_q, col_s_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       row_n_q, row_n_d;
  logic [1:0]       col_lat_q, col_lat_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic [2:0]       select_q, select_d;

  logic             tick;
  logic             any_pressed;
  logic [1:0]       pressed_col;
  logic [1:0]       row_idx;
  logic [3:0]       row_next;

  assign tick     = (div_q == DIV_W'(SCAN_DIV - 1));
  assign row_next = {row_n_q[2:0], row_n_q[3]};

  // Lowest-index column pulled low on the synchronized column bus.
  always_comb begin
    any_pressed = 1'b0;
    pressed_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s_q[i]) begin
        any_pressed = 1'b1;
        pressed_col = 2'(i);
      end
    end
  end

  // Index of the row currently driven low (row drive is always one-hot).
  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_n_q[i]) begin
        row_idx = 2'(i);
      end
    end
  end

  // Next-state logic: synchronizer, dwell divider, scan/debounce/held FSM.
  always_comb begin
    col_meta_d  = col_n;
    col_s_d     = col_meta_q;
    div_d       = tick ? '0 : div_q + 1'b1;
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_n_d     = row_n_q;
    col_lat_d   = col_lat_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    select_d    = select_q;
    if (tick) begin
      case (state_q)
        S_SCAN: begin
          if (any_pressed) begin
            // Row stays put so the candidate key keeps being sampled.
            col_lat_d = pressed_col;
            cnt_d     = CNT_W'(1);
            state_d   = S_DEB;
          end else begin
            row_n_d = row_next;
          end
        end
        S_DEB: begin
          if (any_pressed && (pressed_col == col_lat_q)) begin
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
              state_d     = S_HELD;
              cnt_d       = '0;
              key_code_d  = {row_idx, col_lat_q};
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              // Codes 0-7 live in rows 0 and 1 only.
              if (!row_idx[1]) begin
                select_d = {row_idx[0], col_lat_q};
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            // Bounce or a different key: give up and keep scanning.
            cnt_d   = '0;
            state_d = S_SCAN;
            row_n_d = row_next;
          end
        end
        S_HELD: begin
          // Only the latched column matters; other keys in the row are ignored.
          if (col_s_q[col_lat_q]) begin
            if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
              cnt_d      = '0;
              key_held_d = 1'b0;
              state_d    = S_SCAN;
              row_n_d    = row_next;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = S_SCAN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SCAN;
      col_meta_q  <= 4'b1111;
      col_s_q     <= 4'b1111;
      div_q       <= '0;
      cnt_q       <= '0;
      row_n_q     <= 4'b1110;
      col_lat_q   <= 2'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      select_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      col_meta_q  <= col_meta_d;
      col_s_q     <= col_s_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      row_n_q     <= row_n_d;
      col_lat_q   <= col_lat_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      select_q    <= select_d;
    end
  end

  assign row_n     = row_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign select    = select_q;

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// tb_keypad_scanner: drives a modelled 4x4 key matrix and compares every
// cycle against a key-level reference model of the scanner.
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DEB = 3;

  logic       clk;
  logic       rst_n;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [2:0] select;

  logic [15:0] keys;

  int n_vec  = 0;
  int n_miss = 0;
  int pulses = 0;

  // Reference model state (key numbers and plain integers)
  logic [3:0] m_s1, m_s2;
  int m_div, m_row, cand, streak;
  int exp_code, exp_sel;
  bit exp_valid, exp_held;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .select   (select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its column to its row when driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_low(input logic [3:0] v);
    for (int c = 0; c < 4; c++) if (!v[c]) return c;
    return -1;
  endfunction

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF;
    m_div = 0; m_row = 0; cand = -1; streak = 0;
    exp_code = 0; exp_sel = 0; exp_valid = 0; exp_held = 0;
  endtask

  // One clock edge of the scanner's behaviour, seen as keys and rows.
  task automatic model_step(input logic [3:0] cn);
    bit t;
    int pc;
    t = (m_div == SD - 1);
    m_div = (m_div + 1) % SD;
    exp_valid = 0;
    if (t) begin
      pc = lowest_low(m_s2);
      if (exp_held) begin
        if (m_s2[cand % 4]) streak++;
        else streak = 0;
        if (streak == DEB) begin
          exp_held = 0; cand = -1; streak = 0;
          m_row = (m_row + 1) % 4;
        end
      end else if (cand < 0) begin
        if (pc < 0) m_row = (m_row + 1) % 4;
        else begin
          cand = m_row * 4 + pc;
          streak = 1;
        end
      end else begin
        if (pc == cand % 4) begin
          streak++;
          if (streak == DEB) begin
            exp_valid = 1; exp_held = 1; exp_code = cand; streak = 0;
            if (cand <= 7) exp_sel = cand;
          end
        end else begin
          cand = -1; streak = 0;
          m_row = (m_row + 1) % 4;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = cn;
  endtask

  // Called at a falling edge: advance one clock and compare all outputs.
  task automatic tick_cycle();
    logic [3:0] exp_row;
    #1;
    model_step(col_n);
    @(negedge clk);
    exp_row = 4'b0001 << m_row;
    check_eq("outs", {3'b000, row_n, key_code, key_valid, key_held, select},
             {3'b000, ~exp_row, 4'(exp_code), exp_valid, exp_held, 3'(exp_sel)});
    if (key_valid) begin
      pulses++;
      $display("key_valid code=%0d select=%0d held=%0d t=%0t", key_code, select, key_held, $time);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick_cycle();
      if (key_valid) seen = 1;
    end
    if (!seen) check_eq(tag, 16'(seen), 16'd1);
  endtask

  task automatic wait_release(input string tag, input int budget);
    bit done;
    done = !key_held;
    for (int i = 0; i < budget && !done; i++) begin
      tick_cycle();
      if (!key_held) done = 1;
    end
    if (!done) check_eq(tag, 16'(done), 16'd1);
  endtask

  task automatic wait_row(input logic [3:0] target, input int budget);
    bit hit;
    hit = (row_n == target);
    for (int i = 0; i < budget && !hit; i++) begin
      tick_cycle();
      if (row_n == target) hit = 1;
    end
    if (!hit) check_eq("wait_row", 16'(hit), 16'd1);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_row",   16'(row_n),     16'h000E);
    check_eq("rst_code",  16'(key_code),  16'd0);
    check_eq("rst_valid", 16'(key_valid), 16'd0);
    check_eq("rst_held",  16'(key_held),  16'd0);
    check_eq("rst_sel",   16'(select),    16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int p0;
    int sel;
    keys  = 16'h0000;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle rotation
    p0 = pulses;
    run(40);
    check_eq("idle_novalid", 16'(pulses - p0), 16'd0);

    // Key 9: code 9, held, select untouched, single pulse
    p0 = pulses;
    keys = 16'h0001 << 9;
    wait_valid("k9_timeout", 200);
    check_eq("k9_code", 16'(key_code), 16'd9);
    check_eq("k9_held", 16'(key_held), 16'd1);
    check_eq("k9_sel",  16'(select),   16'd0);
    run(40);
    check_eq("k9_once", 16'(pulses - p0), 16'd1);
    keys = 16'h0000;
    wait_release("k9_rel_timeout", 200);
    check_eq("k9_keep", 16'(key_code), 16'd9);
    run(8);

    // Key 5 loads select; key 12 leaves it
    keys = 16'h0001 << 5;
    wait_valid("k5_timeout", 200);
    check_eq("k5_code", 16'(key_code), 16'd5);
    check_eq("k5_sel",  16'(select),   16'd5);
    keys = 16'h0000;
    wait_release("k5_rel_timeout", 200);
    keys = 16'h0001 << 12;
    wait_valid("k12_timeout", 200);
    check_eq("k12_code", 16'(key_code), 16'd12);
    check_eq("k12_sel",  16'(select),   16'd5);
    keys = 16'h0000;
    wait_release("k12_rel_timeout", 200);

    // Bounce: key 2 present for a single tick only
    wait_row(4'b1110, 100);
    p0 = pulses;
    keys = 16'h0001 << 2;
    run(5);
    keys = 16'h0000;
    run(30);
    check_eq("bounce_novalid", 16'(pulses - p0), 16'd0);

    // Two keys in row 0: lowest column wins
    keys = 16'h0005;
    wait_valid("dual_timeout", 200);
    check_eq("dual_code", 16'(key_code), 16'd0);
    check_eq("dual_sel",  16'(select),   16'd0);
    keys = 16'h0000;
    wait_release("dual_rel_timeout", 200);

    // Reset while key 3 is held, then a fresh acceptance of the same key
    keys = 16'h0001 << 3;
    wait_valid("k3_timeout", 200);
    check_eq("k3_code", 16'(key_code), 16'd3);
    run(6);
    apply_reset();
    p0 = pulses;
    wait_valid("k3_again_timeout", 200);
    check_eq("k3_again_code", 16'(key_code), 16'd3);
    check_eq("k3_again_sel",  16'(select),   16'd3);
    check_eq("k3_again_once", 16'(pulses - p0), 16'd1);
    keys = 16'h0000;
    wait_release("k3_rel_timeout", 200);

    // Randomized key activity against the model
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 3) keys = 16'h0000;
      else if (sel < 9) keys = 16'h0001 << $urandom_range(0, 15);
      else keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      run($urandom_range(1, 60));
    end
    keys = 16'h0000;
    run(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Scans a 4x4 active-low key matrix on the board user-input header. It drives one row low at a time, samples the columns, debounces one key, and reports its hex code with a one-cycle valid strobe. It also keeps a 3-bit display-select register updated from keys 0-7. This register feeds the select input of the segment display driver, so the keypad is the input end of the board UI and the segment display driver is the output end.

Parameters:
SCAN_DIV, 16, clock cycles per row dwell and per sample tick (>=2)
DEBOUNCE, 4, consecutive identical samples needed to accept a press or a release (>=2)

Ports:
clk        input   1  system clock; single clock domain
rst_n      input   1  asynchronous reset, active-low
col_n      input   4  matrix column lines, active-low, asynchronous to clk
row_n      output  4  matrix row drive, one-hot active-low
key_code   output  4  last accepted key, row*4+col
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_held   output  1  high from acceptance until the debounced release
select     output  3  display select register

Behaviour:
- Reset (async, rst_n=0):
  - row_n=4'b1110 (row 0); key_code=0; key_valid=0; key_held=0; select=0.
  - State=SCAN; dwell counter=0; sample counter=0; col synchronizer=4'b1111.
- Input sync: col_n passes through a 2-FF synchronizer. All decisions use the synchronized value, col_s.
- Tick: the dwell counter runs 0..SCAN_DIV-1 and wraps. tick=1 when counter==SCAN_DIV-1. All sampling happens only on tick cycles.
- "Pressed column" = lowest index c with col_s[c]=0. No column low means none.
- SCAN state:
  - On tick with none pressed: row_n rotates left (1110->1101->1011->0111->1110).
  - On tick with a column pressed: latch current row r and column c, set count=1, go DEBOUNCE. Row does not advance.
- DEBOUNCE state:
  - On tick, same column c pressed: count++.
  - When count reaches DEBOUNCE: go HELD. On the same edge, key_code<=r*4+c, key_valid<=1 for exactly one cycle, key_held<=1.
  - On tick, a different column or none pressed: count=0, go SCAN, row advances on that tick.
- HELD state:
  - Row stays at r; other rows are ignored.
  - On tick, col c released: rcount++. On tick, col c still low: rcount=0.
  - When rcount reaches DEBOUNCE: key_held<=0, go SCAN, row advances to r+1 mod 4.
  - A second key in the same row is ignored while held.
- Latency: from the first detecting tick to key_valid high = (DEBOUNCE-1)*SCAN_DIV+1 clocks. The column change itself reaches col_s 2 clocks after it appears on col_n.
- Select register:
  - In the cycle key_valid is driven high, if the new code <= 7, select<=code[2:0] (registered alongside key_code).
  - Codes 8-15 leave select unchanged.
  - select holds its value otherwise; there is no auto-increment.
- key_code holds its last value until the next acceptance. It is not cleared on release.
- No repeat: holding a key produces exactly one key_valid.
- Simultaneous keys in different rows: the first row reached by the scan wins.
- Reset mid-DEBOUNCE or mid-HELD: all outputs return to reset values immediately. No key_valid is emitted during or after reset until a full new debounce completes.
- All outputs are registered; there are no combinational paths from col_n.

Test Plan:
(Bench uses SCAN_DIV=4, DEBOUNCE=3.)
- Reset: assert rst_n=0 mid-run -> row_n=1110, key_code=0, key_valid=0, key_held=0, select=0 asynchronously.
- Idle rotation: col_n=1111 for 40 cycles -> row_n steps 1110,1101,1011,0111,1110 every 4 cycles; key_valid never high.
- Press key 9 (row 2, col 1): hold col_n[1]=0 while row_n=1011 -> single key_valid pulse, key_code=9, key_held=1, select unchanged. Release -> key_held=0 after 3 released ticks, then row_n=0111 next.
- Press key 5 (row 1, col 1) -> key_code=5, select=3'b101. Then press key 12 -> key_code=12, select stays 5.
- Bounce: col low for 1 tick then high -> no key_valid, state back to SCAN, row advances. Two keys in row 0 at cols 0 and 2 -> key_code=0.
- Reset during HELD of key 3 -> key_held=0 immediately. After reset, the still-pressed key 3 produces a fresh key_valid only after 3 ticks on row 0.
